// File: rtl/alias_bus_arbiter.sv
// Round-robin, packet-locked arbiter: one requester owns the shared bus for a
// whole packet; beats leave through a single registered output stage tagged with their source.
module alias_bus_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 128,
  localparam int SRCW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_ready,
  output logic [31:0]           pkt_count,
  output logic                  o_dbg_state
);

  // Handshake: a beat moves on any edge where valid && ready are both high;
  // req_ready never depends on req_valid, and out_valid/out_data stay stable while out_ready is low.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_state;
  logic [SRCW-1:0]  r_grant;
  logic [SRCW-1:0]  r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SRCW-1:0]  r_out_src;
  logic [31:0]      r_pkt_count;

  logic             w_any;
  logic [SRCW-1:0]  w_pick;
  logic             w_can_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_last;
  logic [SRCW-1:0]  w_next_ptr;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any  = 1'b1;
        w_pick = SRCW'(idx);
      end
    end
  end

  assign w_can_load = !r_out_valid || out_ready;
  assign w_gnt_data = req_data[r_grant*WIDTH +: WIDTH];
  assign w_gnt_last = req_last[r_grant];
  assign w_xfer     = (r_state == ST_LOCK) && req_valid[r_grant] && w_can_load;
  assign w_next_ptr = (r_grant == SRCW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCK) req_ready[r_grant] = w_can_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          // A granted requester that stalls keeps the lock; there is no timeout.
          if (w_xfer && w_gnt_last) begin
            r_pkt_count <= r_pkt_count + 32'd1;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_last  <= w_gnt_last;
        r_out_src   <= r_grant;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_src     = r_out_src;
  assign pkt_count   = r_pkt_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alias_bus_arbiter.sv
// Directed bench for alias_bus_arbiter: per-requester beat queues feed the DUT,
// expected beats go into exp_q and a monitor pops/compares each accepted output beat.
module tb_alias_bus_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 128;
  localparam int EW   = 2 + 1 + W;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [1:0]        out_src;
  logic              out_ready;
  logic [31:0]       pkt_count;
  logic              dbg_state;

  alias_bus_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .pkt_count  (pkt_count),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [EW-1:0] exp_q[$];
  logic [W:0]    src_mem[NREQ][32];
  int            src_head[NREQ];
  int            src_tail[NREQ];
  logic [NREQ-1:0] gate;
  int total;
  int bad;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // driver tasks
  task automatic push_beat(input int r, input logic [W-1:0] d, input logic l);
    src_mem[r][src_tail[r]] = {l, d};
    src_tail[r]++;
  endtask

  task automatic expect_beat(input logic [1:0] s, input logic [W-1:0] d, input logic l);
    exp_q.push_back({s, l, d});
  endtask

  function automatic logic busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREQ; i++) if (src_head[i] < src_tail[i]) b = 1'b1;
    return b;
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    gate = '0;
  endtask

  task automatic driver_loop();
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && src_head[i] < src_tail[i]) src_head[i]++;
      for (int i = 0; i < NREQ; i++) begin
        if (src_head[i] < src_tail[i] && !gate[i]) begin
          req_valid[i]         = 1'b1;
          req_last[i]          = src_mem[i][src_head[i]][W];
          req_data[i*W +: W]   = src_mem[i][src_head[i]][W-1:0];
        end else begin
          req_valid[i]         = 1'b0;
          req_last[i]          = 1'b0;
          req_data[i*W +: W]   = '0;
        end
      end
    end
  endtask

  // scoreboard monitor
  task automatic monitor_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", {out_src, out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_src, out_last, out_data}, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy() || dbg_state) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail(name);
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] d);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid && out_data == d) found = 1'b1;
    end
    if (!found) fail(name);
  endtask

  logic [10:0] pat;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    clear_sources();
    fork
      monitor_loop();
      driver_loop();
    join_none

    @(negedge clk);
    chk("rst_ctrl", {out_valid, out_last, out_src, pkt_count, dbg_state, req_ready}, '0);
    chk("rst_data", out_data, '0);
    do_reset();
    chk("post_rst_state", {dbg_state, pkt_count}, '0);

    // single beat from requester 0: out_valid two cycles after req_valid rises
    push_beat(0, 128'hA5, 1'b1);
    expect_beat(2'd0, 128'hA5, 1'b1);
    @(negedge clk);
    chk("t1_cyc0", {out_valid, req_ready, dbg_state}, {1'b0, 4'b0000, 1'b0});
    @(negedge clk);
    chk("t1_cyc1", {out_valid, req_ready, dbg_state}, {1'b0, 4'b0001, 1'b1});
    @(negedge clk);
    chk("t1_cyc2", {out_valid, out_src, out_last, out_data}, {1'b1, 2'd0, 1'b1, 128'hA5});
    chk("t1_pkt", pkt_count, 32'd1);
    wait_idle("t1_idle");

    // all four requesters, single-beat packets from reset: 0,1,2,3,0 with bubbles
    do_reset();
    push_beat(0, 128'hB0, 1'b1);
    push_beat(1, 128'hB1, 1'b1);
    push_beat(2, 128'hB2, 1'b1);
    push_beat(3, 128'hB3, 1'b1);
    push_beat(0, 128'hB4, 1'b1);
    expect_beat(2'd0, 128'hB0, 1'b1);
    expect_beat(2'd1, 128'hB1, 1'b1);
    expect_beat(2'd2, 128'hB2, 1'b1);
    expect_beat(2'd3, 128'hB3, 1'b1);
    expect_beat(2'd0, 128'hB4, 1'b1);
    pat = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      pat[k] = out_valid;
    end
    chk("t2_bubbles", pat, 11'b10101010100);
    wait_idle("t2_idle");
    chk("t2_pkt", pkt_count, 32'd5);

    // 3-beat packet from requester 2, then 3 and 1 in round-robin order
    push_beat(2, 128'hD0, 1'b0);
    push_beat(2, 128'hD1, 1'b0);
    push_beat(2, 128'hD2, 1'b1);
    expect_beat(2'd2, 128'hD0, 1'b0);
    expect_beat(2'd2, 128'hD1, 1'b0);
    expect_beat(2'd2, 128'hD2, 1'b1);
    expect_beat(2'd3, 128'hC3, 1'b1);
    expect_beat(2'd1, 128'hC1, 1'b1);
    pat = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      pat[k] = out_valid;
      if (k == 1) begin
        push_beat(1, 128'hC1, 1'b1);
        push_beat(3, 128'hC3, 1'b1);
      end
    end
    chk("t3_stream", pat[8:0], 9'b101011100);
    wait_idle("t3_idle");
    chk("t3_pkt", pkt_count, 32'd8);

    // downstream stall of 5 cycles mid-packet
    push_beat(0, 128'hE0, 1'b0);
    push_beat(0, 128'hE1, 1'b0);
    push_beat(0, 128'hE2, 1'b0);
    push_beat(0, 128'hE3, 1'b1);
    expect_beat(2'd0, 128'hE0, 1'b0);
    expect_beat(2'd0, 128'hE1, 1'b0);
    expect_beat(2'd0, 128'hE2, 1'b0);
    expect_beat(2'd0, 128'hE3, 1'b1);
    wait_out("t4_wait_e1", 128'hE1);
    @(posedge clk);
    #2 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall", {out_valid, req_ready, out_data}, {1'b1, 4'b0000, 128'hE2});
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_pkt", pkt_count, 32'd9);

    // granted requester 1 pauses 3 cycles while 0 and 2 request
    push_beat(1, 128'hF0, 1'b0);
    push_beat(1, 128'hF1, 1'b0);
    push_beat(1, 128'hF2, 1'b1);
    push_beat(0, 128'h50, 1'b1);
    push_beat(2, 128'h52, 1'b1);
    expect_beat(2'd1, 128'hF0, 1'b0);
    expect_beat(2'd1, 128'hF1, 1'b0);
    expect_beat(2'd1, 128'hF2, 1'b1);
    expect_beat(2'd2, 128'h52, 1'b1);
    expect_beat(2'd0, 128'h50, 1'b1);
    wait_out("t5_wait_f0", 128'hF0);
    gate[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_gap", {dbg_state, req_ready}, {1'b1, 4'b0010});
    end
    gate[1] = 1'b0;
    wait_idle("t5_idle");
    chk("t5_pkt", pkt_count, 32'd12);

    // asynchronous reset in the middle of a packet from requester 3
    push_beat(3, 128'h60, 1'b0);
    push_beat(3, 128'h61, 1'b0);
    push_beat(3, 128'h62, 1'b0);
    push_beat(3, 128'h63, 1'b1);
    expect_beat(2'd3, 128'h60, 1'b0);
    expect_beat(2'd3, 128'h61, 1'b0);
    wait_out("t6_wait_g1", 128'h61);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {out_valid, out_last, out_src, pkt_count, dbg_state, req_ready}, '0);
    chk("t6_async_data", out_data, '0);
    chk("t6_seen_beats", exp_q.size(), 0);
    clear_sources();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_beat(0, 128'h70, 1'b1);
    push_beat(3, 128'h73, 1'b1);
    expect_beat(2'd0, 128'h70, 1'b1);
    expect_beat(2'd3, 128'h73, 1'b1);
    wait_idle("t6_idle");
    chk("t6_pkt", pkt_count, 32'd2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
